// File: rtl/edge_evt_pkg.sv
// Shared definitions for the edge-event arbiter: edge type codes, FSM states
// and a constant ceil-log2 helper used for index widths.
package edge_evt_pkg;

  localparam logic EDGE_RISE = 1'b1;
  localparam logic EDGE_FALL = 1'b0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } evt_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/edge_sync_detect.sv
// One channel: metastability synchroniser, previous-level register and
// arm-gated rise/fall pulse generation.
module edge_sync_detect #(
  parameter int SYNC_STAGES = 2
)(
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic data_in,
  input  logic armed_in,
  input  logic pos_en_in,
  input  logic neg_en_in,
  output logic rise_out,
  output logic fall_out
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   prev_p1;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      sync_p0 <= '0;
      prev_p1 <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], data_in};
      prev_p1 <= sync_p0[SYNC_STAGES-1];
    end
  end

  // Stage p1 -> slot: pulses stay masked until the chain has flushed post-reset.
  assign rise_out = armed_in & pos_en_in &  sync_p0[SYNC_STAGES-1] & ~prev_p1;
  assign fall_out = armed_in & neg_en_in & ~sync_p0[SYNC_STAGES-1] &  prev_p1;

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event scheduler: per-channel edge detection, one pending
// slot per channel, and a round-robin valid/ready event port.
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter  int CH_NUM      = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int IDX_W       = clog2(CH_NUM)
)(
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [CH_NUM-1:0] data_in,
  input  logic [CH_NUM-1:0] pos_en_in,
  input  logic [CH_NUM-1:0] neg_en_in,
  output logic              evt_valid_out,
  input  logic              evt_ready_in,
  output logic [IDX_W-1:0]  evt_ch_out,
  output logic              evt_pos_out,
  output logic [CH_NUM-1:0] ovf_out,
  input  logic              ovf_clr_in
);

  localparam int               ARM_W    = clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

  logic [ARM_W-1:0]  arm_cnt;
  logic              armed;
  logic [CH_NUM-1:0] rise, fall;
  logic [CH_NUM-1:0] vld_p2, typ_p2;
  logic [CH_NUM-1:0] vld_d, typ_d, ovf_set, unload;
  evt_state_e        state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W:0]    pick;
  logic              grant_vld;
  logic [IDX_W-1:0]  grant_idx;
  logic              load;

  // Returns {found, index} of the first request after ptr, wrapping around.
  function automatic logic [IDX_W:0] rr_pick(input logic [CH_NUM-1:0] req,
                                             input logic [IDX_W-1:0]  ptr);
    logic [IDX_W:0] r;
    int             c;
    r = '0;
    for (int k = CH_NUM; k >= 1; k--) begin
      c = (int'(ptr) + k) % CH_NUM;
      if (req[c]) r = {1'b1, IDX_W'(c)};
    end
    return r;
  endfunction

  always_ff @(posedge clk_in) begin
    if (!rst_n_in)   arm_cnt <= '0;
    else if (!armed) arm_cnt <= arm_cnt + ARM_W'(1);
  end

  assign armed = (arm_cnt == ARM_DONE);

  for (genvar g = 0; g < CH_NUM; g++) begin : g_det
    edge_sync_detect #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_det (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .data_in   (data_in[g]),
      .armed_in  (armed),
      .pos_en_in (pos_en_in[g]),
      .neg_en_in (neg_en_in[g]),
      .rise_out  (rise[g]),
      .fall_out  (fall[g])
    );
  end

  assign pick      = rr_pick(vld_p2, rr_ptr);
  assign grant_vld = pick[IDX_W];
  assign grant_idx = pick[IDX_W-1:0];
  assign load      = grant_vld && ((state == ST_IDLE) || evt_ready_in);

  // Slot update: a full slot only accepts a new edge when it is drained this cycle.
  always_comb begin
    vld_d   = vld_p2;
    typ_d   = typ_p2;
    ovf_set = '0;
    unload  = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      unload[c] = load && (grant_idx == IDX_W'(c));
      if (unload[c]) vld_d[c] = 1'b0;
      if (rise[c] || fall[c]) begin
        if (vld_p2[c] && !unload[c]) begin
          ovf_set[c] = 1'b1;
        end else begin
          vld_d[c] = 1'b1;
          typ_d[c] = rise[c] ? EDGE_RISE : EDGE_FALL;
        end
      end
    end
  end

  // Stage p2: pending slots and sticky overflow.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      vld_p2  <= '0;
      typ_p2  <= '0;
      ovf_out <= '0;
    end else begin
      vld_p2  <= vld_d;
      typ_p2  <= typ_d;
      ovf_out <= (ovf_out & ~{CH_NUM{ovf_clr_in}}) | ovf_set;
    end
  end

  // Output stage: event held until accepted, next grant loaded on the same edge.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state         <= ST_IDLE;
      evt_valid_out <= 1'b0;
      evt_ch_out    <= '0;
      evt_pos_out   <= 1'b0;
      rr_ptr        <= IDX_W'(CH_NUM - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (load) begin
            state         <= ST_HOLD;
            evt_valid_out <= 1'b1;
            evt_ch_out    <= grant_idx;
            evt_pos_out   <= typ_p2[grant_idx];
            rr_ptr        <= grant_idx;
          end
        end
        ST_HOLD: begin
          if (load) begin
            evt_ch_out  <= grant_idx;
            evt_pos_out <= typ_p2[grant_idx];
            rr_ptr      <= grant_idx;
          end else if (evt_ready_in) begin
            state         <= ST_IDLE;
            evt_valid_out <= 1'b0;
          end
        end
        default: begin
          state         <= ST_IDLE;
          evt_valid_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Randomised and directed bench for edge_event_arbiter against a behavioural
// model built from sampled input history, pending slots and round-robin order.
module tb_edge_event_arbiter;

  localparam int CH = 4;
  localparam int S  = 2;

  logic          clk;
  logic          rst_n;
  logic [CH-1:0] data, pos_en, neg_en, ovf;
  logic          valid, ready, pos, clr;
  logic [1:0]    ch;

  int n_checks = 0;
  int n_errors = 0;

  edge_event_arbiter #(
    .CH_NUM      (CH),
    .SYNC_STAGES (S)
  ) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .data_in       (data),
    .pos_en_in     (pos_en),
    .neg_en_in     (neg_en),
    .evt_valid_out (valid),
    .evt_ready_in  (ready),
    .evt_ch_out    (ch),
    .evt_pos_out   (pos),
    .ovf_out       (ovf),
    .ovf_clr_in    (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  bit          m_smp [CH][S+1];
  bit          m_pend[CH];
  bit          m_typ [CH];
  bit          m_valid, m_pos;
  int          m_ch, m_ptr, m_age;
  bit [CH-1:0] m_ovf;
  logic [2:0]  delivered[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    int g, unl;
    bit ev, et;
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) begin
        for (int k = 0; k <= S; k++) m_smp[c][k] = 1'b0;
        m_pend[c] = 1'b0;
        m_typ[c]  = 1'b0;
      end
      m_valid = 1'b0; m_ch = 0; m_pos = 1'b0; m_ovf = '0;
      m_ptr = CH - 1; m_age = 0;
    end else begin
      g = -1;
      for (int k = 1; k <= CH; k++)
        if (g < 0 && m_pend[(m_ptr + k) % CH]) g = (m_ptr + k) % CH;
      unl = -1;
      if (!m_valid || ready) begin
        if (g >= 0) begin
          unl = g; m_valid = 1'b1; m_ch = g; m_pos = m_typ[g]; m_ptr = g;
        end else begin
          m_valid = 1'b0;
        end
      end
      if (clr) m_ovf = '0;
      for (int c = 0; c < CH; c++) begin
        ev = 1'b0; et = 1'b0;
        if (m_age >= S + 1) begin
          if (m_smp[c][S-1] && !m_smp[c][S] && pos_en[c]) begin ev = 1'b1; et = 1'b1; end
          if (!m_smp[c][S-1] && m_smp[c][S] && neg_en[c]) begin ev = 1'b1; et = 1'b0; end
        end
        if (ev) begin
          if (m_pend[c] && unl != c) m_ovf[c] = 1'b1;
          else begin m_pend[c] = 1'b1; m_typ[c] = et; end
        end else if (unl == c) begin
          m_pend[c] = 1'b0;
        end
        for (int k = S; k >= 1; k--) m_smp[c][k] = m_smp[c][k-1];
        m_smp[c][0] = data[c];
      end
      if (m_age < S + 1) m_age++;
    end
  endtask

  task automatic tick();
    if (rst_n && valid && ready) delivered.push_back({pos, ch});
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("valid", valid, m_valid);
    if (m_valid) begin
      chk("ch", ch, m_ch);
      chk("pos", pos, m_pos);
    end
    chk("ovf", ovf, m_ovf);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst_n = 1'b0; data = 4'b0001; pos_en = '1; neg_en = '1; ready = 1'b1; clr = 1'b0;

    // Reset state and arming with ch0 held high through reset
    ticks(3);
    chk("rst_valid", valid, 0);
    chk("rst_ch", ch, 0);
    chk("rst_pos", pos, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin tick(); seen |= int'(valid); end
    chk("arm_no_evt", seen, 0);

    // Single rise latency on ch2
    data = 4'b0000; ticks(10);
    data[2] = 1'b1;
    ticks(3);
    chk("lat_early", valid, 0);
    tick();
    chk("lat_valid", valid, 1);
    chk("lat_ch", ch, 2);
    chk("lat_pos", pos, 1);
    tick();
    chk("lat_one_cycle", valid, 0);

    // Contention from a fresh reset
    rst_n = 1'b0; data = 4'b0000; tick();
    rst_n = 1'b1; ticks(6);
    delivered.delete();
    data = 4'b1111; ticks(10);
    chk("cont_count", delivered.size(), 4);
    if (delivered.size() == 4)
      for (int i = 0; i < 4; i++) chk("cont_order", delivered[i], {1'b1, 2'(i)});

    // Backpressure and overflow on ch1
    data = 4'b0000; ticks(15);
    ready = 1'b0; delivered.delete();
    data[1] = 1'b1; ticks(8);
    data[1] = 1'b0; ticks(8);
    data[1] = 1'b1; ticks(8);
    chk("bp_ovf", ovf, 4'b0010);
    chk("bp_none_yet", delivered.size(), 0);
    ready = 1'b1; ticks(10);
    chk("bp_count", delivered.size(), 2);
    if (delivered.size() == 2) begin
      chk("bp_first", delivered[0], 3'b101);
      chk("bp_second", delivered[1], 3'b001);
    end
    clr = 1'b1; tick();
    clr = 1'b0;
    chk("bp_clr", ovf, 0);

    // Falling edge masked on ch3
    neg_en = 4'b0111; delivered.delete();
    data[3] = 1'b1; ticks(10);
    data[3] = 1'b0; ticks(15);
    chk("mask_count", delivered.size(), 1);
    if (delivered.size() == 1) chk("mask_evt", delivered[0], 3'b111);
    neg_en = '1;

    // Reset while an event is held and an overflow is flagged
    ready = 1'b0;
    data[0] = 1'b1; ticks(6);
    data[0] = 1'b0; ticks(6);
    data[0] = 1'b1; ticks(6);
    chk("mid_pre_valid", valid, 1);
    chk("mid_pre_ovf", ovf[0], 1);
    rst_n = 1'b0; tick();
    chk("mid_valid", valid, 0);
    chk("mid_ovf", ovf, 0);
    rst_n = 1'b1; ready = 1'b1; delivered.delete(); ticks(15);
    chk("mid_no_stale", delivered.size(), 0);

    // Randomised traffic
    for (int n = 0; n < 2000; n++) begin
      int idx;
      if ($urandom_range(0, 7) == 0) begin
        idx = $urandom_range(0, CH - 1);
        data[idx] = ~data[idx];
      end
      if (n < 1000) ready = ($urandom_range(0, 3) != 0);
      else          ready = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 63) == 0) begin
        pos_en = CH'($urandom);
        neg_en = CH'($urandom);
      end
      clr   = ($urandom_range(0, 39) == 0);
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
